conv_layer_engine: RTL and testbench
====================================

Name: conv_layer_engine

Overview:
Parametrised successor to the fixed 8x8 / 3x3 / 6-lane convolution layer. Generalises image size, kernel size and feature count. Uses signed fixed-point arithmetic, backpressure on the feature output, and self-generated pixel and weight ROM addresses. Sits between the external pixel ROM and weight ROM and the pooling stage; emits one output row of all lanes per valid/ready beat.

Parameters:
DATA_WIDTH, 16, signed fixed-point pixel/weight/feature width
FRAC_BITS, 8, fractional bits of DATA_WIDTH format
ACC_WIDTH, 40, per-lane accumulator width (>= 2*DATA_WIDTH + clog2(KERNEL_SIZE^2))
IMG_WIDTH, 8, input image columns
IMG_HEIGHT, 8, input image rows
KERNEL_SIZE, 3, square kernel edge K
NUM_FEATURES, 4, number of kernels (output feature maps)
ADDR_WIDTH, 12, pixel/weight ROM address width
Derived: OUT_W = IMG_WIDTH-K+1 (lane count), OUT_H = IMG_HEIGHT-K+1

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-high (port named per codebase, asserted = 1)
enable  in  1  start pulse, sampled only in IDLE
data_in  in  DATA_WIDTH  pixel ROM read data, 1-cycle latency after ext_rom_addr
weight_in  in  DATA_WIDTH  weight ROM read data, 1-cycle latency after weight_addr
out_ready  in  1  downstream accepts feature row
ext_rom_addr  out  ADDR_WIDTH  pixel address = (row+ky)*IMG_WIDTH + x
weight_addr  out  ADDR_WIDTH  weight address = f*K*K + ky*K + kx
busy  out  1  high in any state except IDLE
valid  out  1  feature_output holds a completed row
feature_output  out  OUT_W*DATA_WIDTH  lane 0 in MSBs; zero when valid=0
feature_idx  out  clog2(NUM_FEATURES)  feature of current row
feature_row  out  clog2(OUT_H)  output row index
image_calc_fin  out  1  one-cycle pulse after last row of last feature accepted

Behaviour:
- Reset: state IDLE; all counters, accumulators and row buffer cleared; every output 0. Reset mid-operation aborts immediately; no partial output.
- States: IDLE, LOAD_ROW, MAC, OUTPUT, FIN.
- IDLE: enable=1 -> LOAD_ROW with f=0, row=0, ky=0, accumulators cleared. enable outside IDLE is ignored.
- LOAD_ROW: lasts IMG_WIDTH+1 cycles. Addresses x=0..IMG_WIDTH-1 are issued on cycles 0..IMG_WIDTH-1. data_in captured into row_buf[x] one cycle later. Then -> MAC with kx=0.
- MAC: lasts K+1 cycles. weight_addr for kx is issued on cycle kx. On cycle kx+1: acc[i] += row_buf[i+kx]*weight_in for all i in 0..OUT_W-1, in parallel.
  - Product: full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Then ky++. If ky<K -> LOAD_ROW, else -> OUTPUT.
- OUTPUT: valid=1. Lane i = sat_DATA_WIDTH(acc[i] >>> FRAC_BITS), arithmetic shift. Saturation clamps to 0x7FFF / 0x8000 for DATA_WIDTH=16.
  - Output, feature_idx, feature_row and addresses hold stable while out_ready=0.
  - On valid&&out_ready: clear accumulators, ky=0; advance row, wrapping to 0 and incrementing f.
  - If last row of last feature -> FIN, else -> LOAD_ROW. valid drops the cycle after the handshake.
- FIN: image_calc_fin=1 for exactly one cycle -> IDLE. An enable in that IDLE cycle starts a new image.
- Cycles per output row (excluding stall): K*(IMG_WIDTH+K+2)+1 (=40 for defaults).
- ext_rom_addr and weight_addr hold their last value when not issuing.

Optional Feature:
CONV_LAYER_RELU_EN: when defined, any negative saturated lane is replaced by 0 before feature_output. When undefined, signed values pass unchanged. Timing is identical either way.

Test Plan:
- Reset: rst_n=1 for 2 cycles mid-MAC -> next cycle busy=0, valid=0, feature_output=0, ext_rom_addr=0, weight_addr=0.
- All pixels 0x0100 (1.0), all weights 0x0100, out_ready=1 -> 24 valid beats (4 features x 6 rows), every lane 0x0900. feature_idx/feature_row step 0/0..3/5. image_calc_fin pulses once, one cycle after beat 24.
- Pixel(x,y)=(x+y)<<8, feature-0 kernel centre=0x0100 and others 0 -> feature 0, row r, lane i = (i+r+2)<<8. First valid at cycle 40 after enable.
- out_ready=0 for 10 cycles at feature 1, row 2 -> valid stays 1; feature_output, feature_idx, feature_row and addresses are stable. Resumes correctly after release.
- Pixels 0x7FFF, weights 0x7FFF -> lanes 0x7FFF. Weights 0x8000 -> lanes 0x8000 without CONV_LAYER_RELU_EN, 0x0000 with it.
- enable pulsed while busy -> ignored, sequence unchanged. Reset mid-image then enable -> outputs bit-identical to a clean run.

Source files
------------

// File: rtl/conv_layer_engine_if.sv
// Handshake/bus bundle between conv_layer_engine, its pixel/weight ROMs and the pooling stage.
// Latency: none (wires only).
// Backpressure: out_ready carries the downstream stall back to the engine.
// Ports: enable/data_in/weight_in/out_ready toward the engine; ROM addresses, busy, valid,
//        feature_output/idx/row and image_calc_fin from the engine.
// slave modport = engine side, master modport = environment side.
interface conv_layer_engine_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_FEATURES = 4
);
  localparam int OUT_W  = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H  = IMG_HEIGHT - KERNEL_SIZE + 1;
  localparam int FIDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int FROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic                        enable;
  logic [DATA_WIDTH-1:0]       data_in;
  logic [DATA_WIDTH-1:0]       weight_in;
  logic                        out_ready;
  logic [ADDR_WIDTH-1:0]       ext_rom_addr;
  logic [ADDR_WIDTH-1:0]       weight_addr;
  logic                        busy;
  logic                        valid;
  logic [OUT_W*DATA_WIDTH-1:0] feature_output;
  logic [FIDX_W-1:0]           feature_idx;
  logic [FROW_W-1:0]           feature_row;
  logic                        image_calc_fin;

  modport slave (
    input  enable, data_in, weight_in, out_ready,
    output ext_rom_addr, weight_addr, busy, valid, feature_output,
           feature_idx, feature_row, image_calc_fin
  );

  modport master (
    output enable, data_in, weight_in, out_ready,
    input  ext_rom_addr, weight_addr, busy, valid, feature_output,
           feature_idx, feature_row, image_calc_fin
  );
endinterface

// File: rtl/conv_layer_engine.sv
// Parametrised valid-kernel convolution: one output row of all lanes per feature per beat.
// Latency: K*(IMG_WIDTH+K+2)+1 cycles per output row from start/previous handshake.
// Backpressure: row, indices and ROM addresses hold in OUTPUT while out_ready is low.
// Ports: clk, rst_n (synchronous, active-high despite the name), eng_if (slave modport):
//   enable start pulse, data_in/weight_in ROM data (1-cycle latency), out_ready,
//   ext_rom_addr/weight_addr, busy, valid, feature_output (lane 0 in MSBs),
//   feature_idx, feature_row, image_calc_fin.
// Optional macro CONV_LAYER_RELU_EN: clamp negative saturated lanes to zero.
module conv_layer_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_FEATURES = 4,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_layer_engine_if.slave eng_if
);
  localparam int K      = KERNEL_SIZE;
  localparam int OUT_W  = IMG_WIDTH - K + 1;
  localparam int OUT_H  = IMG_HEIGHT - K + 1;
  localparam int FIDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int FROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CNT_W  = $clog2(((IMG_WIDTH > K) ? IMG_WIDTH : K) + 1);
  localparam int KY_W   = $clog2(K + 1);
  localparam int BUF_IW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_ROW, MAC, OUTPUT, FIN} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [KY_W-1:0]              ky_q, ky_d;
  logic [FIDX_W-1:0]            f_q, f_d;
  logic [FROW_W-1:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0]        ext_addr_q, ext_addr_d;
  logic [ADDR_WIDTH-1:0]        wt_addr_q, wt_addr_d;
  logic signed [DATA_WIDTH-1:0] row_buf_q [IMG_WIDTH];
  logic signed [ACC_WIDTH-1:0]  acc_q [OUT_W];
  logic signed [PW-1:0]         prod [OUT_W];
  logic signed [ACC_WIDTH-1:0]  shifted [OUT_W];
  logic [DATA_WIDTH-1:0]        lane [OUT_W];
  logic [OUT_W*DATA_WIDTH-1:0]  fo;
  logic [BUF_IW-1:0]            kx;
  logic                         acc_clr, acc_en;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ky_d    = ky_q;
    f_d     = f_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (eng_if.enable) begin
          state_d = LOAD_ROW;
          cnt_d   = '0;
          ky_d    = '0;
          f_d     = '0;
          row_d   = '0;
        end
      end
      LOAD_ROW: begin
        // One extra cycle so the last ROM word lands in row_buf.
        if (cnt_q == CNT_W'(IMG_WIDTH)) begin
          state_d = MAC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MAC: begin
        if (cnt_q == CNT_W'(K)) begin
          cnt_d   = '0;
          ky_d    = ky_q + KY_W'(1);
          state_d = (ky_q == KY_W'(K - 1)) ? OUTPUT : LOAD_ROW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUTPUT: begin
        if (eng_if.out_ready) begin
          ky_d    = '0;
          cnt_d   = '0;
          state_d = LOAD_ROW;
          if (row_q == FROW_W'(OUT_H - 1)) begin
            row_d = '0;
            if (f_q == FIDX_W'(NUM_FEATURES - 1)) begin
              f_d     = '0;
              state_d = FIN;
            end else begin
              f_d = f_q + FIDX_W'(1);
            end
          end else begin
            row_d = row_q + FROW_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ROM addresses are driven only while issuing; otherwise the last value is held.
  always_comb begin
    ext_addr_d = ext_addr_q;
    wt_addr_d  = wt_addr_q;
    if (state_q == LOAD_ROW && cnt_q < CNT_W'(IMG_WIDTH))
      ext_addr_d = ADDR_WIDTH'((int'(row_q) + int'(ky_q)) * IMG_WIDTH + int'(cnt_q));
    if (state_q == MAC && cnt_q < CNT_W'(K))
      wt_addr_d = ADDR_WIDTH'(int'(f_q) * K * K + int'(ky_q) * K + int'(cnt_q));
  end

  // weight_in for tap kx arrives on MAC cycle kx+1, hence the cnt-1 offset.
  always_comb begin
    kx = '0;
    if (state_q == MAC && cnt_q != '0) kx = BUF_IW'(cnt_q - CNT_W'(1));
    for (int i = 0; i < OUT_W; i++)
      prod[i] = PW'(row_buf_q[BUF_IW'(i) + kx]) * PW'($signed(eng_if.weight_in));
  end

  assign acc_clr = (state_q == IDLE && eng_if.enable) || (state_q == OUTPUT && eng_if.out_ready);
  assign acc_en  = (state_q == MAC) && (cnt_q != '0);

  // Rescale to DATA_WIDTH fixed point with saturation.
  always_comb begin
    fo = '0;
    for (int i = 0; i < OUT_W; i++) begin
      shifted[i] = acc_q[i] >>> FRAC_BITS;
      if (shifted[i] > SAT_MAX)
        lane[i] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (shifted[i] < SAT_MIN)
        lane[i] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
        lane[i] = shifted[i][DATA_WIDTH-1:0];
`ifdef CONV_LAYER_RELU_EN
      if (lane[i][DATA_WIDTH-1]) lane[i] = '0;
`endif
      if (state_q == OUTPUT) fo[(OUT_W-1-i)*DATA_WIDTH +: DATA_WIDTH] = lane[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ky_q       <= '0;
      f_q        <= '0;
      row_q      <= '0;
      ext_addr_q <= '0;
      wt_addr_q  <= '0;
      for (int x = 0; x < IMG_WIDTH; x++) row_buf_q[x] <= '0;
      for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ky_q       <= ky_d;
      f_q        <= f_d;
      row_q      <= row_d;
      ext_addr_q <= ext_addr_d;
      wt_addr_q  <= wt_addr_d;
      if (state_q == LOAD_ROW && cnt_q != '0)
        row_buf_q[BUF_IW'(cnt_q - CNT_W'(1))] <= $signed(eng_if.data_in);
      if (acc_clr) begin
        for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
      end else if (acc_en) begin
        for (int i = 0; i < OUT_W; i++) acc_q[i] <= acc_q[i] + ACC_WIDTH'(prod[i]);
      end
    end
  end

  assign eng_if.ext_rom_addr   = ext_addr_d;
  assign eng_if.weight_addr    = wt_addr_d;
  assign eng_if.busy           = (state_q != IDLE);
  assign eng_if.valid          = (state_q == OUTPUT);
  assign eng_if.feature_output = fo;
  assign eng_if.feature_idx    = f_q;
  assign eng_if.feature_row    = row_q;
  assign eng_if.image_calc_fin = (state_q == FIN);
endmodule

// File: tb/tb_conv_layer_engine.sv
module tb_conv_layer_engine;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int K     = 3;
  localparam int NF    = 4;
  localparam int AW    = 12;
  localparam int OUT_W = IW - K + 1;
  localparam int OUT_H = IH - K + 1;
  localparam int BEATS = NF * OUT_H;
  localparam int ROW_CYC = K * (IW + K + 2) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_layer_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
                         .KERNEL_SIZE(K), .NUM_FEATURES(NF)) bus ();

  conv_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC), .ACC_WIDTH(40), .IMG_WIDTH(IW),
                      .IMG_HEIGHT(IH), .KERNEL_SIZE(K), .NUM_FEATURES(NF), .ADDR_WIDTH(AW))
    dut (.clk(clk), .rst_n(rst_n), .eng_if(bus));

  logic [15:0] pix_mem [64];
  logic [15:0] wt_mem  [64];

  // Synchronous ROMs, one cycle of read latency.
  always @(posedge clk) begin
    bus.data_in   <= pix_mem[bus.ext_rom_addr[5:0]];
    bus.weight_in <= wt_mem[bus.weight_addr[5:0]];
  end

  int total = 0;
  int bad   = 0;

  logic [OUT_W*DW-1:0] q_dat [$];
  int q_f [$];
  int q_r [$];
  int q_cyc [$];
  int first_valid_cyc, fin_cyc, fin_count, timeout, stall_diffs, stall_cycles;
  int cyc;

  // Direct convolution reference.
  function automatic logic [15:0] ref_lane(input int f, input int r, input int i);
    longint s;
    logic [15:0] res;
    s = 0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        s += longint'($signed(pix_mem[(r + ky) * IW + i + kx])) *
             longint'($signed(wt_mem[f * K * K + ky * K + kx]));
    s = s >>> FRAC;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    res = s[15:0];
`ifdef CONV_LAYER_RELU_EN
    if (s < 0) res = 16'h0000;
`endif
    return res;
  endfunction

  function automatic logic [OUT_W*DW-1:0] ref_row(input int f, input int r);
    logic [OUT_W*DW-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++) v[(OUT_W-1-i)*DW +: DW] = ref_lane(f, r, i);
    return v;
  endfunction

  task automatic fill_const(input logic [15:0] p, input logic [15:0] w);
    for (int a = 0; a < 64; a++) begin
      pix_mem[a] = p;
      wt_mem[a]  = w;
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) begin
      pix_mem[a] = 16'($urandom_range(0, 2047)) - 16'h0400;
      wt_mem[a]  = 16'($urandom_range(0, 1023)) - 16'h0200;
    end
  endtask

  // Runs one image; stall_mode 0: always ready, 1: random ready, 2: 10-cycle stall at f1/r2.
  // abort_at>0 returns at that cycle with the engine still mid-image.
  task automatic run_image(input int stall_mode, input bit en_noise, input int abort_at);
    bit ready;
    bit stall_done;
    int stall_left;
    logic [OUT_W*DW-1:0] snap_dat;
    logic [AW-1:0] snap_ea, snap_wa;
    int snap_f, snap_r;
    q_dat.delete(); q_f.delete(); q_r.delete(); q_cyc.delete();
    first_valid_cyc = -1; fin_cyc = -1; fin_count = 0; timeout = 0;
    stall_diffs = 0; stall_cycles = 0; stall_done = 0; stall_left = 0;
    snap_dat = '0; snap_ea = '0; snap_wa = '0; snap_f = 0; snap_r = 0;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    bus.enable = 1'b0;
    while (1) begin
      if (abort_at > 0 && cyc == abort_at) return;
      if (bus.image_calc_fin) begin
        fin_count++;
        fin_cyc = cyc;
        break;
      end
      if (bus.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      ready = 1'b1;
      if (stall_mode == 1) ready = ($urandom_range(0, 3) != 0);
      if (stall_mode == 2 && bus.valid && bus.feature_idx == 1 && bus.feature_row == 2 && !stall_done) begin
        if (stall_left == 0) begin
          snap_dat = bus.feature_output; snap_ea = bus.ext_rom_addr; snap_wa = bus.weight_addr;
          snap_f = int'(bus.feature_idx); snap_r = int'(bus.feature_row);
          stall_left = 10;
        end
        if (bus.feature_output !== snap_dat || bus.ext_rom_addr !== snap_ea ||
            bus.weight_addr !== snap_wa || int'(bus.feature_idx) != snap_f ||
            int'(bus.feature_row) != snap_r)
          stall_diffs++;
        stall_cycles++;
        stall_left--;
        ready = 1'b0;
        if (stall_left == 0) stall_done = 1;
      end
      bus.out_ready = ready;
      if (bus.valid && ready) begin
        q_dat.push_back(bus.feature_output);
        q_f.push_back(int'(bus.feature_idx));
        q_r.push_back(int'(bus.feature_row));
        q_cyc.push_back(cyc);
      end
      bus.enable = (en_noise && bus.busy && $urandom_range(0, 15) == 0);
      if (cyc > 5000) begin
        timeout = 1;
        break;
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    bus.enable = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.image_calc_fin) fin_count++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    total++; if (bus.feature_output !== '0) begin bad++; $display("FAIL reset_fo: got %h expected 0", bus.feature_output); end
    total++; if (bus.ext_rom_addr !== '0 || bus.weight_addr !== '0) begin bad++;
      $display("FAIL reset_addr: got %h/%h expected 0/0", bus.ext_rom_addr, bus.weight_addr); end
    total++; if (bus.image_calc_fin !== 1'b0) begin bad++; $display("FAIL reset_fin: got %b expected 0", bus.image_calc_fin); end
    @(negedge clk);
    rst_n = 1'b0;
    fill_const(16'h0100, 16'h0100);
    run_image(0, 0, 11);
    total++; if (bus.busy !== 1'b1 || bus.weight_addr === '0 && 0) begin bad++;
      $display("FAIL mid_mac_busy: got %b expected 1", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin bad++;
      $display("FAIL abort_state: got busy=%b valid=%b expected 0/0", bus.busy, bus.valid); end
    total++; if (bus.feature_output !== '0) begin bad++; $display("FAIL abort_fo: got %h expected 0", bus.feature_output); end
    total++; if (bus.ext_rom_addr !== '0 || bus.weight_addr !== '0) begin bad++;
      $display("FAIL abort_addr: got %h/%h expected 0/0", bus.ext_rom_addr, bus.weight_addr); end
  endtask

  task automatic test_all_ones();
    fill_const(16'h0100, 16'h0100);
    run_image(0, 0, 0);
    total++; if (timeout != 0 || q_dat.size() != BEATS) begin bad++;
      $display("FAIL ones_beats: got %0d (timeout=%0d) expected %0d", q_dat.size(), timeout, BEATS); end
    total++; if (first_valid_cyc != ROW_CYC) begin bad++;
      $display("FAIL ones_latency: got %0d expected %0d", first_valid_cyc, ROW_CYC); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== {OUT_W{16'h0900}}) begin bad++;
        $display("FAIL ones_data beat %0d: got %h expected all 0900", n, q_dat[n]); end
      total++; if (q_f[n] != n / OUT_H || q_r[n] != n % OUT_H) begin bad++;
        $display("FAIL ones_idx beat %0d: got f%0d r%0d expected f%0d r%0d", n, q_f[n], q_r[n], n / OUT_H, n % OUT_H); end
      total++; if (q_cyc[n] != ROW_CYC * (n + 1)) begin bad++;
        $display("FAIL ones_cycle beat %0d: got %0d expected %0d", n, q_cyc[n], ROW_CYC * (n + 1)); end
    end
    total++; if (fin_count != 1 || fin_cyc != ROW_CYC * BEATS + 1) begin bad++;
      $display("FAIL ones_fin: got count=%0d cyc=%0d expected 1/%0d", fin_count, fin_cyc, ROW_CYC * BEATS + 1); end
  endtask

  task automatic test_ramp();
    logic [15:0] got;
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) pix_mem[y * IW + x] = 16'((x + y) << 8);
    for (int a = 0; a < 64; a++) wt_mem[a] = 16'h0000;
    wt_mem[4] = 16'h0100;
    run_image(0, 0, 0);
    total++; if (timeout != 0 || q_dat.size() != BEATS || first_valid_cyc != ROW_CYC) begin bad++;
      $display("FAIL ramp_run: got beats=%0d first=%0d expected %0d/%0d", q_dat.size(), first_valid_cyc, BEATS, ROW_CYC); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== ref_row(n / OUT_H, n % OUT_H)) begin bad++;
        $display("FAIL ramp_model beat %0d: got %h expected %h", n, q_dat[n], ref_row(n / OUT_H, n % OUT_H)); end
      if (n < OUT_H) begin
        for (int i = 0; i < OUT_W; i++) begin
          got = q_dat[n][(OUT_W-1-i)*DW +: DW];
          total++; if (got !== 16'((i + n + 2) << 8)) begin bad++;
            $display("FAIL ramp_lane r%0d l%0d: got %h expected %h", n, i, got, 16'((i + n + 2) << 8)); end
        end
      end
    end
  endtask

  task automatic test_stall();
    fill_random();
    run_image(2, 0, 0);
    total++; if (stall_cycles != 10 || stall_diffs != 0) begin bad++;
      $display("FAIL stall_hold: got cycles=%0d diffs=%0d expected 10/0", stall_cycles, stall_diffs); end
    total++; if (timeout != 0 || q_dat.size() != BEATS || fin_count != 1) begin bad++;
      $display("FAIL stall_run: got beats=%0d fin=%0d expected %0d/1", q_dat.size(), fin_count, BEATS); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== ref_row(n / OUT_H, n % OUT_H) || q_f[n] != n / OUT_H || q_r[n] != n % OUT_H) begin bad++;
        $display("FAIL stall_model beat %0d: got %h f%0d r%0d expected %h", n, q_dat[n], q_f[n], q_r[n], ref_row(n / OUT_H, n % OUT_H)); end
    end
  endtask

  task automatic test_random_backpressure();
    fill_random();
    run_image(1, 0, 0);
    total++; if (timeout != 0 || q_dat.size() != BEATS || fin_count != 1) begin bad++;
      $display("FAIL rbp_run: got beats=%0d fin=%0d expected %0d/1", q_dat.size(), fin_count, BEATS); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== ref_row(n / OUT_H, n % OUT_H) || q_f[n] != n / OUT_H || q_r[n] != n % OUT_H) begin bad++;
        $display("FAIL rbp_model beat %0d: got %h f%0d r%0d expected %h", n, q_dat[n], q_f[n], q_r[n], ref_row(n / OUT_H, n % OUT_H)); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_neg;
`ifdef CONV_LAYER_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8000;
`endif
    fill_const(16'h7FFF, 16'h7FFF);
    run_image(0, 0, 0);
    total++; if (q_dat.size() != BEATS) begin bad++; $display("FAIL satp_run: got %0d expected %0d", q_dat.size(), BEATS); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== {OUT_W{16'h7FFF}}) begin bad++;
        $display("FAIL sat_pos beat %0d: got %h expected all 7fff", n, q_dat[n]); end
    end
    fill_const(16'h7FFF, 16'h8000);
    run_image(0, 0, 0);
    total++; if (q_dat.size() != BEATS) begin bad++; $display("FAIL satn_run: got %0d expected %0d", q_dat.size(), BEATS); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== {OUT_W{exp_neg}}) begin bad++;
        $display("FAIL sat_neg beat %0d: got %h expected all %h", n, q_dat[n], exp_neg); end
    end
  endtask

  task automatic test_enable_while_busy();
    fill_random();
    run_image(0, 1, 0);
    total++; if (timeout != 0 || q_dat.size() != BEATS || fin_count != 1) begin bad++;
      $display("FAIL enbusy_run: got beats=%0d fin=%0d expected %0d/1", q_dat.size(), fin_count, BEATS); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== ref_row(n / OUT_H, n % OUT_H) || q_cyc[n] != ROW_CYC * (n + 1)) begin bad++;
        $display("FAIL enbusy_beat %0d: got %h at %0d expected %h at %0d", n, q_dat[n], q_cyc[n], ref_row(n / OUT_H, n % OUT_H), ROW_CYC * (n + 1)); end
    end
  endtask

  task automatic test_reset_rerun();
    fill_random();
    run_image(0, 0, 200);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    run_image(0, 0, 0);
    total++; if (timeout != 0 || q_dat.size() != BEATS || first_valid_cyc != ROW_CYC) begin bad++;
      $display("FAIL rerun_run: got beats=%0d first=%0d expected %0d/%0d", q_dat.size(), first_valid_cyc, BEATS, ROW_CYC); end
    for (int n = 0; n < q_dat.size() && n < BEATS; n++) begin
      total++; if (q_dat[n] !== ref_row(n / OUT_H, n % OUT_H) || q_f[n] != n / OUT_H || q_r[n] != n % OUT_H) begin bad++;
        $display("FAIL rerun_beat %0d: got %h f%0d r%0d expected %h", n, q_dat[n], q_f[n], q_r[n], ref_row(n / OUT_H, n % OUT_H)); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.enable = 1'b0;
    bus.out_ready = 1'b1;
    fill_const(16'h0000, 16'h0000);
    test_reset();
    test_all_ones();
    test_ramp();
    test_stall();
    test_random_backpressure();
    test_saturation();
    test_enable_while_busy();
    test_reset_rerun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
